// File: rtl/mul_seq_signed_pkg.sv
// Shared types and elaboration-time helpers for the signed sequential multiplier.
// The FSM state enum is the debug view of the controller (visible as mul_seq_signed.state).
package mul_seq_signed_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  function automatic int ceil_div(input int n, input int d);
    return (n + d - 1) / d;
  endfunction

  // Width of a counter indexing n items, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mul_simple.sv
// Unsigned combinational multiplier used for one partial product per step.
module mul_simple #(
  parameter int A_WIDTH = 32,
  parameter int B_WIDTH = 8,
  parameter int P_WIDTH = 64
) (
  input  logic [A_WIDTH-1:0] a,
  input  logic [B_WIDTH-1:0] b,
  output logic [P_WIDTH-1:0] p
);

  assign p = P_WIDTH'(a) * P_WIDTH'(b);

endmodule

// File: rtl/mul_seq_signed.sv
// Iterative signed/unsigned multiplier: one operand-2 slice per cycle,
// optional early exit, and a one-entry result buffer on the rd_* side.
//
// Handshakes: an operation is accepted at an edge where wr_en & wr_ready;
// a result is popped at an edge where rd_en & rd_ready, and rd_val is high
// for exactly the following cycle. Requests while the ready is low are ignored.
module mul_seq_signed
  import mul_seq_signed_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int PART_DATA_WIDTH = 8,
  parameter int EARLY_OUT       = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wr_en,
  output logic                      wr_ready,
  input  logic [DATA_WIDTH-1:0]     wr_data_1,
  input  logic [DATA_WIDTH-1:0]     wr_data_2,
  input  logic                      wr_signed_1,
  input  logic                      wr_signed_2,
  input  logic                      rd_en,
  output logic                      rd_ready,
  output logic [2*DATA_WIDTH-1:0]   rd_data,
  output logic                      rd_val
);

  localparam int RES_WIDTH  = 2 * DATA_WIDTH;
  localparam int STEP_COUNT = ceil_div(DATA_WIDTH, PART_DATA_WIDTH);
  localparam int EXT_WIDTH  = STEP_COUNT * PART_DATA_WIDTH;
  localparam int STEP_W     = idx_width(STEP_COUNT);

  state_t                 state, state_next;
  logic [DATA_WIDTH-1:0]  mag1;
  logic [EXT_WIDTH-1:0]   mag2;
  logic                   neg;
  logic [RES_WIDTH-1:0]   acc;
  logic [STEP_W-1:0]      step;
  logic                   buf_full;
  logic [RES_WIDTH-1:0]   buf_data;
  logic                   rd_val_q;

  logic                   neg1, neg2;
  logic [DATA_WIDTH-1:0]  abs1, abs2;
  logic                   accept, pop, fix_write;
  logic                   last_step, rem_zero, calc_done;
  logic [PART_DATA_WIDTH-1:0] part;
  logic [RES_WIDTH-1:0]   pp, pp_shifted;

  // Most-negative input has magnitude 2^(DATA_WIDTH-1), which still fits unsigned.
  assign neg1 = wr_signed_1 & wr_data_1[DATA_WIDTH-1];
  assign neg2 = wr_signed_2 & wr_data_2[DATA_WIDTH-1];
  assign abs1 = neg1 ? -wr_data_1 : wr_data_1;
  assign abs2 = neg2 ? -wr_data_2 : wr_data_2;

  assign accept    = wr_en & (state == ST_IDLE);
  assign pop       = rd_en & buf_full;
  assign fix_write = (state == ST_FIX) & (~buf_full | pop);

  always_comb begin
    part = '0;
    for (int i = 0; i < STEP_COUNT; i++) begin
      if (step == STEP_W'(i)) part = mag2[i*PART_DATA_WIDTH +: PART_DATA_WIDTH];
    end
  end

  mul_simple #(
    .A_WIDTH (DATA_WIDTH),
    .B_WIDTH (PART_DATA_WIDTH),
    .P_WIDTH (RES_WIDTH)
  ) u_mul (
    .a (mag1),
    .b (part),
    .p (pp)
  );

  // Constant shifts selected by step; no run-time multiply of the step index.
  always_comb begin
    pp_shifted = '0;
    rem_zero   = 1'b1;
    for (int i = 0; i < STEP_COUNT; i++) begin
      if (step == STEP_W'(i)) begin
        pp_shifted = pp << (i * PART_DATA_WIDTH);
        if (i < STEP_COUNT - 1) rem_zero = ((mag2 >> ((i + 1) * PART_DATA_WIDTH)) == '0);
      end
    end
  end

  assign last_step = (step == STEP_W'(STEP_COUNT - 1));
  assign calc_done = last_step | ((EARLY_OUT != 0) & rem_zero);

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (wr_en)     state_next = ST_CALC;
      ST_CALC: if (calc_done) state_next = ST_FIX;
      ST_FIX:  if (fix_write) state_next = ST_IDLE;
      default:                state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mag1     <= '0;
      mag2     <= '0;
      neg      <= 1'b0;
      acc      <= '0;
      step     <= '0;
      buf_full <= 1'b0;
      buf_data <= '0;
      rd_val_q <= 1'b0;
    end else begin
      rd_val_q <= pop;
      if (accept) begin
        mag1 <= abs1;
        mag2 <= EXT_WIDTH'(abs2);
        neg  <= neg1 ^ neg2;
        acc  <= '0;
        step <= '0;
      end else if (state == ST_CALC) begin
        acc  <= acc + pp_shifted;
        step <= step + 1'b1;
      end
      // A pop and a fresh result on the same edge leave the buffer full.
      if (fix_write) begin
        buf_full <= 1'b1;
        buf_data <= neg ? -acc : acc;
      end else if (pop) begin
        buf_full <= 1'b0;
      end
    end
  end

  assign wr_ready = (state == ST_IDLE);
  assign rd_ready = buf_full;
  assign rd_data  = buf_data;
  assign rd_val   = rd_val_q;

endmodule

// File: doc/mul_seq_signed.md
Name: mul_seq_signed

Overview:
- Multi-cycle iterative multiplier, successor to the team's unsigned sequential multiplier.
- Adds per-operand signed/unsigned mode.
- Adds a one-entry output buffer, so a new operation can start while the previous result waits to be read.
- Adds optional early termination when the upper parts of operand 2 are zero.
- Sits between a producer using the wr_* handshake and a consumer using the rd_* handshake; one operation in flight plus one buffered result.

Parameters:
DATA_WIDTH, 32, operand width (>= 2)
PART_DATA_WIDTH, 8, slice of operand 2 multiplied per cycle (1..DATA_WIDTH)
EARLY_OUT, 1, 1 = stop iterating once the remaining operand-2 parts are zero; 0 = always STEP_COUNT cycles
Derived localparams (not overridable): RES_WIDTH = 2*DATA_WIDTH; STEP_COUNT = ceil(DATA_WIDTH/PART_DATA_WIDTH)

Ports:
clk  in  1  clock, all logic on posedge
reset  in  1  synchronous, active-low; 0 at a posedge resets the block
wr_en  in  1  request to start an operation
wr_ready  out  1  block can accept an operation
wr_data_1  in  DATA_WIDTH  operand 1
wr_data_2  in  DATA_WIDTH  operand 2
wr_signed_1  in  1  operand 1 is two's complement
wr_signed_2  in  1  operand 2 is two's complement
rd_en  in  1  consumer pops the result
rd_ready  out  1  valid result held in the output buffer
rd_data  out  RES_WIDTH  product, two's complement if either operand is signed
rd_val  out  1  one-cycle pulse the cycle after a successful pop

Behaviour:
- Reset (reset=0 at a posedge):
  - state=IDLE, out buffer empty, accumulator=0.
  - Outputs: wr_ready=1, rd_ready=0, rd_data=0, rd_val=0.
  - Reset mid-operation discards the operation and the buffered result.
- FSM states: IDLE, CALC, FIX. wr_ready = (state==IDLE).
- IDLE:
  - wr_en & wr_ready at edge E0 latches mag1=|op1|, mag2=|op2| (a magnitude is taken only when the matching signed bit is set and the MSB is 1).
  - Latches neg = sign1 XOR sign2; clears acc and step; goes to CALC.
  - wr_en while wr_ready=0 is ignored (no latch, no error).
- CALC, step s:
  - acc += (mag1 * part[s]) << (s*PART_DATA_WIDTH), where part[s] is bits of mag2 zero-extended to STEP_COUNT*PART_DATA_WIDTH.
  - Go to FIX after s==STEP_COUNT-1.
  - With EARLY_OUT=1, also go to FIX when (mag2 >> ((s+1)*PART_DATA_WIDTH)) == 0.
- FIX:
  - If the out buffer is empty, or is being popped this same edge: buffer <= neg ? -acc : acc, state <= IDLE.
  - Otherwise stall in FIX with acc held.
- Latency (accept edge to rd_ready=1):
  - STEP_COUNT+1 edges with EARLY_OUT=0.
  - (k+1) edges with EARLY_OUT=1, where k = index of highest nonzero part of mag2 plus 1 (min 1).
- Output buffer:
  - rd_ready = buffer full; rd_data is stable while full.
  - rd_en & rd_ready empties it at the edge; rd_val=1 for exactly the next cycle.
  - rd_en while empty is ignored, rd_val stays 0.
  - Simultaneous pop and FIX write: buffer stays full with the new value; rd_val pulses.
- Back-to-back operation: while a result is buffered, the next operation may be accepted and compute; it stalls only in FIX.
- Width rules:
  - Magnitude of -2^(DATA_WIDTH-1) fits in DATA_WIDTH unsigned bits.
  - Product fits in RES_WIDTH; no overflow possible.
  - Negation is modulo 2^RES_WIDTH.
- Partial-product shift is done by an adder-tree-free constant-shift mux indexed by step; no run-time multiply by PART_DATA_WIDTH.

Decomposition:
- Shared package: FSM state encoding (IDLE/CALC/FIX), clog2-based width helpers, ceil-div function for STEP_COUNT.
- Sub-module: reuse mul_simple (DATA_WIDTH x PART_DATA_WIDTH -> RES_WIDTH) for the per-step partial product.
- Magnitude/negation logic is inline.

Test Plan:
- Unsigned, EARLY_OUT=0, op1=0xFFFFFFFF, op2=0xFFFFFFFF -> rd_ready 5 edges after accept, rd_data=0xFFFFFFFE00000001, rd_val pulses once after pop.
- Signed both, op1=-3 (0xFFFFFFFD), op2=7 -> rd_data=0xFFFFFFFFFFFFFFEB (-21); op1=0x80000000, op2=0x80000000 signed -> 0x4000000000000000.
- Mixed mode, op1 signed -1, op2 unsigned 0xFFFFFFFF -> rd_data=0xFFFFFFFF00000001; same operands both unsigned -> 0xFFFFFFFE00000001.
- EARLY_OUT=1, op2=3, op1=5 -> rd_ready 2 edges after accept, rd_data=15; op2=0x01000000 -> 5 edges; op2=0 -> 2 edges, rd_data=0.
- Back-to-back: hold rd_en=0, issue 2 ops -> wr_ready returns 1 after the first, second stalls in FIX (wr_ready=0); pop on the same edge as FIX -> buffer shows the second result next cycle, no result lost.
- reset=0 during CALC and again with a full buffer -> next cycle wr_ready=1, rd_ready=0, rd_data=0; wr_en/rd_en with ready low -> no state change.
